hex_refresh_ctrl: RTL and testbench
===================================

HEX_REFRESH_CTRL -- requirements
Module: hex_refresh_ctrl

Interface
REQ-001 Parameters, one per line: name, default, meaning.
  BLINK_DIV  25_000_000  clk cycles per blink half-period; legal range 2..2^25.
REQ-002 Ports, one per line: name, direction, width, meaning.
  clk        in   1  single clock, rising edge.
  reset_n    in   1  asynchronous, active-low reset.
  wr_valid   in   1  digit write request.
  wr_ready   out  1  write accept; a write completes when wr_valid && wr_ready at a rising edge.
  wr_idx     in   3  target digit, 0..5.
  wr_val     in   3  3-bit digit code, 0..7.
  wr_blank   in   1  1 = digit dark.
  blink_mask in   6  bit i = 1 makes digit i blink.
  dec_bcd    out  3  code driven to the single shared 3-bit-to-7-segment decoder.
  dec_leds   in   7  active-low pattern returned by that decoder, combinational from dec_bcd.
  hex0..hex5 out  7  each; registered active-low segment drive per digit.
  busy       out  1  1 = state != IDLE or any dirty bit set.

Function
REQ-003 Internal per-digit table, i = 0..5: value[i] (3 b), blank[i] (1 b), dirty[i] (1 b). The block also holds rr_ptr (0..5), blink counter blk_cnt, blink_phase, and FSM state IDLE/FETCH/LATCH.
REQ-004 wr_ready = 1 whenever reset_n is high, with no dependence on state.
REQ-005 Accepted write with wr_idx <= 5: value, blank and dirty[wr_idx] are set to wr_val, wr_blank and 1 at that edge.
REQ-006 Accepted write with wr_idx 6 or 7: no state change.
REQ-007 blk_cnt counts 0..BLINK_DIV-1 and wraps to 0. At the wrap edge, blink_phase toggles and dirty |= blink_mask.
REQ-008 Effective blank: eb[i] = blank[i] | (blink_mask[i] & blink_phase).
REQ-009 IDLE, no dirty bit set: remain in IDLE.
REQ-010 IDLE, any dirty bit set: select cur = first dirty index searching rr_ptr, rr_ptr+1, ... mod 6. At the same edge:
  - dec_bcd <= value[cur];
  - snapshot eb_s <= eb[cur];
  - dirty[cur] <= 0;
  - state <= FETCH.
REQ-011 FETCH: one settling cycle with dec_bcd held; state <= LATCH.
REQ-012 LATCH, at the edge leaving LATCH:
  - hex[cur] <= eb_s ? 7'h7F : dec_leds;
  - rr_ptr <= (cur+1) mod 6;
  - state <= IDLE.
REQ-013 dec_bcd holds its value in IDLE after a service completes; it changes only on IDLE->FETCH.
REQ-014 Latency: a write accepted at edge t into an idle block with no other dirty bits updates hex[wr_idx] at edge t+3.
REQ-015 A write to index cur at the same edge its dirty bit is cleared (REQ-010): set wins. The digit stays dirty and is re-serviced later with the new value.
REQ-016 A write to cur while in FETCH/LATCH does not alter the in-flight dec_bcd/eb_s and sets dirty[cur] again.
REQ-017 Blink wrap and write to the same digit in one cycle: dirty ends 1 and the table takes the write.
REQ-018 Each digit is serviced at most 3 cycles per pass; no starvation: any dirty digit is serviced within 6 services.
REQ-019 hex outputs change only in LATCH (or on reset). Non-serviced digits hold their value.

Reset
REQ-020 reset_n low asynchronously forces:
  - hex0..hex5 = 7'h7F, dec_bcd = 0;
  - value = 0, blank = 1, dirty = 0;
  - rr_ptr = 0, blk_cnt = 0, blink_phase = 0;
  - state = IDLE, busy = 0, wr_ready = 0.
REQ-021 Reset asserted mid-FETCH/LATCH abandons the service with no partial hex update. After release the block is idle until a write or blink wrap.
REQ-022 The first edge after reset_n rises behaves as a normal cycle, with no extra wait state.

Verification
REQ-023 Reset: hold reset_n low 3 cycles, release -> hex0..5 = 7'h7F, busy = 0, wr_ready = 1, dec_bcd = 0.
REQ-024 Single write idx 2, val 2, blank 0 at edge t -> hex2 = 7'h24 at edge t+3, other hex = 7'h7F, busy high until edge t+3.
REQ-025 Writes idx 5/val 7, idx 0/val 0, idx 1/val 1 on consecutive edges t, t+1, t+2 from reset state -> service order 5, 0, 1:
  - hex5 = 7'h78 at t+3;
  - hex0 = 7'h40 at t+6;
  - hex1 = 7'h79 at t+9.
REQ-026 BLINK_DIV = 4, write idx 0/val 7, blink_mask = 6'b000001 -> hex0 alternates 7'h78 / 7'h7F, changing 3 cycles after each blink wrap. Other digits are never serviced.
REQ-027 Write idx 6 -> accepted, table, hex and busy unchanged. Write idx 3 during its own LATCH -> hex3 shows the old value, then the new value one service later.
REQ-028 reset_n low during FETCH of idx 4 -> hex4 stays 7'h7F, all dirty = 0, state IDLE immediately (asynchronous).

Source files
------------

// File: rtl/hex_refresh_ctrl.sv
// Six-digit 7-segment refresh controller. The digits share one external 3-bit-to-7-segment
// decoder. Dirty digits are serviced round-robin through IDLE -> FETCH -> LATCH.
// Digits flagged in blink_mask toggle dark/lit every BLINK_DIV cycles.
module hex_refresh_ctrl #(
    parameter int unsigned BLINK_DIV = 25_000_000
) (
    input  logic       clk,
    input  logic       reset_n,
    input  logic       wr_valid,
    output logic       wr_ready,
    input  logic [2:0] wr_idx,
    input  logic [2:0] wr_val,
    input  logic       wr_blank,
    input  logic [5:0] blink_mask,
    output logic [2:0] dec_bcd,
    input  logic [6:0] dec_leds,
    output logic [6:0] hex0,
    output logic [6:0] hex1,
    output logic [6:0] hex2,
    output logic [6:0] hex3,
    output logic [6:0] hex4,
    output logic [6:0] hex5,
    output logic       busy
);

    localparam int unsigned CntW = 25;
    localparam logic [CntW-1:0] CntMax = CntW'(BLINK_DIV - 1);

    typedef enum logic [1:0] {StIdle, StFetch, StLatch} state_e;

    state_e               state_q, state_d;
    logic [5:0][2:0]      value_q, value_d;
    logic [5:0]           blank_q, blank_d;
    logic [5:0]           dirty_q, dirty_d;
    logic [5:0][6:0]      hex_q, hex_d;
    logic [2:0]           rr_ptr_q, rr_ptr_d;
    logic [2:0]           cur_q, cur_d;
    logic [2:0]           dec_bcd_q, dec_bcd_d;
    logic                 eb_s_q, eb_s_d;
    logic [CntW-1:0]      blk_cnt_q, blk_cnt_d;
    logic                 blink_phase_q, blink_phase_d;

    logic       sel_found;
    logic [2:0] sel_idx;
    logic [3:0] cand;
    logic       blink_wrap;
    logic       wr_fire;

    // The write port never stalls; it is only held off while in reset.
    assign wr_ready = reset_n;
    assign wr_fire  = wr_valid && wr_ready && (wr_idx <= 3'd5);
    assign busy     = (state_q != StIdle) || (|dirty_q);
    assign dec_bcd  = dec_bcd_q;
    assign hex0     = hex_q[0];
    assign hex1     = hex_q[1];
    assign hex2     = hex_q[2];
    assign hex3     = hex_q[3];
    assign hex4     = hex_q[4];
    assign hex5     = hex_q[5];

    // Round-robin pick of the first dirty digit, starting at rr_ptr.
    always_comb begin
        sel_found = 1'b0;
        sel_idx   = 3'd0;
        cand      = 4'd0;
        for (int k = 0; k < 6; k++) begin
            cand = {1'b0, rr_ptr_q} + 4'(k);
            if (cand >= 4'd6) cand = cand - 4'd6;
            if (!sel_found && dirty_q[cand[2:0]]) begin
                sel_found = 1'b1;
                sel_idx   = cand[2:0];
            end
        end
    end

    // Next-state: blink timer, service FSM, then the write port (a write beats a clear).
    always_comb begin
        state_d       = state_q;
        value_d       = value_q;
        blank_d       = blank_q;
        dirty_d       = dirty_q;
        hex_d         = hex_q;
        rr_ptr_d      = rr_ptr_q;
        cur_d         = cur_q;
        dec_bcd_d     = dec_bcd_q;
        eb_s_d        = eb_s_q;
        blink_phase_d = blink_phase_q;

        blink_wrap = (blk_cnt_q == CntMax);
        blk_cnt_d  = blink_wrap ? '0 : blk_cnt_q + 1'b1;

        case (state_q)
            StIdle: begin
                if (sel_found) begin
                    cur_d            = sel_idx;
                    dec_bcd_d        = value_q[sel_idx];
                    eb_s_d           = blank_q[sel_idx] | (blink_mask[sel_idx] & blink_phase_q);
                    dirty_d[sel_idx] = 1'b0;
                    state_d          = StFetch;
                end
            end
            StFetch: state_d = StLatch;
            StLatch: begin
                hex_d[cur_q] = eb_s_q ? 7'h7F : dec_leds;
                rr_ptr_d     = (cur_q == 3'd5) ? 3'd0 : cur_q + 3'd1;
                state_d      = StIdle;
            end
            default: state_d = StIdle;
        endcase

        // Applied after the service clear so a phase change is never lost.
        if (blink_wrap) begin
            blink_phase_d = ~blink_phase_q;
            dirty_d       = dirty_d | blink_mask;
        end

        if (wr_fire) begin
            value_d[wr_idx] = wr_val;
            blank_d[wr_idx] = wr_blank;
            dirty_d[wr_idx] = 1'b1;
        end
    end

    // State registers with asynchronous active-low reset.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state_q       <= StIdle;
            value_q       <= '0;
            blank_q       <= '1;
            dirty_q       <= '0;
            hex_q         <= {6{7'h7F}};
            rr_ptr_q      <= 3'd0;
            cur_q         <= 3'd0;
            dec_bcd_q     <= 3'd0;
            eb_s_q        <= 1'b0;
            blk_cnt_q     <= '0;
            blink_phase_q <= 1'b0;
        end else begin
            state_q       <= state_d;
            value_q       <= value_d;
            blank_q       <= blank_d;
            dirty_q       <= dirty_d;
            hex_q         <= hex_d;
            rr_ptr_q      <= rr_ptr_d;
            cur_q         <= cur_d;
            dec_bcd_q     <= dec_bcd_d;
            eb_s_q        <= eb_s_d;
            blk_cnt_q     <= blk_cnt_d;
            blink_phase_q <= blink_phase_d;
        end
    end

endmodule

// File: tb/tb_hex_refresh_ctrl.sv
// Directed bench for hex_refresh_ctrl with a behavioural model of the shared decoder.
module tb_hex_refresh_ctrl;

    logic       clk;
    logic       reset_n;
    logic       wr_valid;
    logic       wr_ready;
    logic [2:0] wr_idx;
    logic [2:0] wr_val;
    logic       wr_blank;
    logic [5:0] blink_mask;
    logic [2:0] dec_bcd;
    logic [6:0] dec_leds;
    logic [6:0] hex0, hex1, hex2, hex3, hex4, hex5;
    logic       busy;
    logic [6:0] hex_w [6];

    int n_pass  = 0;
    int n_total = 0;

    hex_refresh_ctrl #(.BLINK_DIV(4)) dut (
        .clk       (clk),
        .reset_n   (reset_n),
        .wr_valid  (wr_valid),
        .wr_ready  (wr_ready),
        .wr_idx    (wr_idx),
        .wr_val    (wr_val),
        .wr_blank  (wr_blank),
        .blink_mask(blink_mask),
        .dec_bcd   (dec_bcd),
        .dec_leds  (dec_leds),
        .hex0      (hex0),
        .hex1      (hex1),
        .hex2      (hex2),
        .hex3      (hex3),
        .hex4      (hex4),
        .hex5      (hex5),
        .busy      (busy)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // External active-low 7-segment decoder.
    always_comb begin
        case (dec_bcd)
            3'd0: dec_leds = 7'h40;
            3'd1: dec_leds = 7'h79;
            3'd2: dec_leds = 7'h24;
            3'd3: dec_leds = 7'h30;
            3'd4: dec_leds = 7'h19;
            3'd5: dec_leds = 7'h12;
            3'd6: dec_leds = 7'h02;
            default: dec_leds = 7'h78;
        endcase
    end

    always_comb begin
        hex_w[0] = hex0;
        hex_w[1] = hex1;
        hex_w[2] = hex2;
        hex_w[3] = hex3;
        hex_w[4] = hex4;
        hex_w[5] = hex5;
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic set_wr(input logic v, input logic [2:0] idx, input logic [2:0] val,
                          input logic blank);
        wr_valid = v;
        wr_idx   = idx;
        wr_val   = val;
        wr_blank = blank;
    endtask

    task automatic apply_reset();
        set_wr(1'b0, 3'd0, 3'd0, 1'b0);
        reset_n = 1'b0;
        repeat (3) tick();
        reset_n = 1'b1;
    endtask

    task automatic test_reset();
        set_wr(1'b0, 3'd0, 3'd0, 1'b0);
        reset_n = 1'b0;
        repeat (3) tick();
        n_total++;
        if (wr_ready !== 1'b0) $display("FAIL reset_wr_ready_low: got %b want 0", wr_ready);
        else n_pass++;
        reset_n = 1'b1;
        #1;
        for (int i = 0; i < 6; i++) begin
            n_total++;
            if (hex_w[i] !== 7'h7F) $display("FAIL reset_hex%0d: got %h want 7f", i, hex_w[i]);
            else n_pass++;
        end
        n_total++;
        if (busy !== 1'b0) $display("FAIL reset_busy: got %b want 0", busy);
        else n_pass++;
        n_total++;
        if (wr_ready !== 1'b1) $display("FAIL reset_wr_ready: got %b want 1", wr_ready);
        else n_pass++;
        n_total++;
        if (dec_bcd !== 3'd0) $display("FAIL reset_dec_bcd: got %0d want 0", dec_bcd);
        else n_pass++;
    endtask

    task automatic test_single();
        apply_reset();
        set_wr(1'b1, 3'd2, 3'd2, 1'b0);
        tick();  // edge t
        set_wr(1'b0, 3'd0, 3'd0, 1'b0);
        n_total++;
        if (busy !== 1'b1) $display("FAIL single_busy_t: got %b want 1", busy);
        else n_pass++;
        tick();
        tick();  // t+2
        n_total++;
        if (hex2 !== 7'h7F) $display("FAIL single_hex2_early: got %h want 7f", hex2);
        else n_pass++;
        n_total++;
        if (busy !== 1'b1) $display("FAIL single_busy_t2: got %b want 1", busy);
        else n_pass++;
        tick();  // t+3
        for (int i = 0; i < 6; i++) begin
            n_total++;
            if (hex_w[i] !== ((i == 2) ? 7'h24 : 7'h7F))
                $display("FAIL single_hex%0d: got %h want %h", i, hex_w[i],
                         (i == 2) ? 7'h24 : 7'h7F);
            else n_pass++;
        end
        n_total++;
        if (busy !== 1'b0) $display("FAIL single_busy_done: got %b want 0", busy);
        else n_pass++;
        tick();
        tick();
        n_total++;
        if (dec_bcd !== 3'd2) $display("FAIL single_dec_hold: got %0d want 2", dec_bcd);
        else n_pass++;
    endtask

    task automatic test_order();
        apply_reset();
        set_wr(1'b1, 3'd5, 3'd7, 1'b0);
        tick();  // t
        set_wr(1'b1, 3'd0, 3'd0, 1'b0);
        tick();  // t+1
        set_wr(1'b1, 3'd1, 3'd1, 1'b0);
        tick();  // t+2
        set_wr(1'b0, 3'd0, 3'd0, 1'b0);
        tick();  // t+3
        n_total++;
        if (hex5 !== 7'h78) $display("FAIL order_hex5: got %h want 78", hex5);
        else n_pass++;
        n_total++;
        if (hex0 !== 7'h7F) $display("FAIL order_hex0_early: got %h want 7f", hex0);
        else n_pass++;
        tick();
        tick();  // t+5
        n_total++;
        if (hex0 !== 7'h7F) $display("FAIL order_hex0_t5: got %h want 7f", hex0);
        else n_pass++;
        tick();  // t+6
        n_total++;
        if (hex0 !== 7'h40) $display("FAIL order_hex0: got %h want 40", hex0);
        else n_pass++;
        n_total++;
        if (hex1 !== 7'h7F) $display("FAIL order_hex1_early: got %h want 7f", hex1);
        else n_pass++;
        tick();
        tick();
        tick();  // t+9
        n_total++;
        if (hex1 !== 7'h79) $display("FAIL order_hex1: got %h want 79", hex1);
        else n_pass++;
        n_total++;
        if (busy !== 1'b0) $display("FAIL order_busy_done: got %b want 0", busy);
        else n_pass++;
    endtask

    task automatic test_blink();
        logic [6:0] exp;
        blink_mask = 6'b000001;
        apply_reset();
        set_wr(1'b1, 3'd0, 3'd7, 1'b0);
        // Wraps land on edges 4, 8, 12, 16 after release.
        for (int e = 1; e <= 16; e++) begin
            tick();
            if (e == 1) set_wr(1'b0, 3'd0, 3'd0, 1'b0);
            if (e <= 3) exp = 7'h7F;
            else if (e <= 6) exp = 7'h78;
            else if (e <= 10) exp = 7'h7F;
            else if (e <= 14) exp = 7'h78;
            else exp = 7'h7F;
            n_total++;
            if (hex0 !== exp) $display("FAIL blink_hex0_e%0d: got %h want %h", e, hex0, exp);
            else n_pass++;
        end
        for (int i = 1; i < 6; i++) begin
            n_total++;
            if (hex_w[i] !== 7'h7F) $display("FAIL blink_hex%0d: got %h want 7f", i, hex_w[i]);
            else n_pass++;
        end
        blink_mask = 6'b000000;
    endtask

    task automatic test_bad_idx();
        apply_reset();
        set_wr(1'b1, 3'd6, 3'd5, 1'b0);
        tick();
        set_wr(1'b1, 3'd7, 3'd3, 1'b0);
        tick();
        set_wr(1'b0, 3'd0, 3'd0, 1'b0);
        n_total++;
        if (busy !== 1'b0) $display("FAIL bad_idx_busy: got %b want 0", busy);
        else n_pass++;
        repeat (4) tick();
        n_total++;
        if (busy !== 1'b0) $display("FAIL bad_idx_busy_late: got %b want 0", busy);
        else n_pass++;
        n_total++;
        if (dec_bcd !== 3'd0) $display("FAIL bad_idx_dec: got %0d want 0", dec_bcd);
        else n_pass++;
        for (int i = 0; i < 6; i++) begin
            n_total++;
            if (hex_w[i] !== 7'h7F) $display("FAIL bad_idx_hex%0d: got %h want 7f", i, hex_w[i]);
            else n_pass++;
        end
    endtask

    task automatic test_latch_write();
        apply_reset();
        set_wr(1'b1, 3'd3, 3'd3, 1'b0);
        tick();  // edge1: dirty3
        set_wr(1'b0, 3'd0, 3'd0, 1'b0);
        tick();  // edge2: now in FETCH
        tick();  // edge3: now in LATCH
        set_wr(1'b1, 3'd3, 3'd5, 1'b0);
        tick();  // edge4: hex3 latched with old value, new write accepted
        set_wr(1'b0, 3'd0, 3'd0, 1'b0);
        n_total++;
        if (hex3 !== 7'h30) $display("FAIL latch_wr_old: got %h want 30", hex3);
        else n_pass++;
        n_total++;
        if (busy !== 1'b1) $display("FAIL latch_wr_busy: got %b want 1", busy);
        else n_pass++;
        tick();
        tick();
        n_total++;
        if (hex3 !== 7'h30) $display("FAIL latch_wr_hold: got %h want 30", hex3);
        else n_pass++;
        tick();
        n_total++;
        if (hex3 !== 7'h12) $display("FAIL latch_wr_new: got %h want 12", hex3);
        else n_pass++;
        n_total++;
        if (busy !== 1'b0) $display("FAIL latch_wr_idle: got %b want 0", busy);
        else n_pass++;
    endtask

    task automatic test_set_wins();
        apply_reset();
        set_wr(1'b1, 3'd3, 3'd3, 1'b0);
        tick();  // edge1: dirty3
        set_wr(1'b1, 3'd3, 3'd4, 1'b1);
        tick();  // edge2: service of 3 starts with value 3 while write lands
        set_wr(1'b0, 3'd0, 3'd0, 1'b0);
        n_total++;
        if (dec_bcd !== 3'd3) $display("FAIL set_wins_dec: got %0d want 3", dec_bcd);
        else n_pass++;
        tick();
        tick();  // edge4
        n_total++;
        if (hex3 !== 7'h30) $display("FAIL set_wins_first: got %h want 30", hex3);
        else n_pass++;
        n_total++;
        if (busy !== 1'b1) $display("FAIL set_wins_busy: got %b want 1", busy);
        else n_pass++;
        tick();  // edge5: re-service, blanked write
        n_total++;
        if (dec_bcd !== 3'd4) $display("FAIL set_wins_dec2: got %0d want 4", dec_bcd);
        else n_pass++;
        tick();
        tick();  // edge7
        n_total++;
        if (hex3 !== 7'h7F) $display("FAIL set_wins_blank: got %h want 7f", hex3);
        else n_pass++;
    endtask

    task automatic test_reset_mid();
        apply_reset();
        set_wr(1'b1, 3'd4, 3'd6, 1'b0);
        tick();  // edge1
        set_wr(1'b0, 3'd0, 3'd0, 1'b0);
        tick();  // edge2: FETCH of 4
        n_total++;
        if (dec_bcd !== 3'd6) $display("FAIL reset_mid_dec_pre: got %0d want 6", dec_bcd);
        else n_pass++;
        #1 reset_n = 1'b0;
        #1;
        n_total++;
        if (busy !== 1'b0) $display("FAIL reset_mid_busy: got %b want 0", busy);
        else n_pass++;
        n_total++;
        if (dec_bcd !== 3'd0) $display("FAIL reset_mid_dec: got %0d want 0", dec_bcd);
        else n_pass++;
        tick();
        tick();
        reset_n = 1'b1;
        repeat (6) tick();
        n_total++;
        if (hex4 !== 7'h7F) $display("FAIL reset_mid_hex4: got %h want 7f", hex4);
        else n_pass++;
        n_total++;
        if (busy !== 1'b0) $display("FAIL reset_mid_idle: got %b want 0", busy);
        else n_pass++;
    endtask

    initial begin
        reset_n    = 1'b0;
        blink_mask = 6'b000000;
        set_wr(1'b0, 3'd0, 3'd0, 1'b0);
        test_reset();
        test_single();
        test_order();
        test_blink();
        test_bad_idx();
        test_latch_write();
        test_set_wins();
        test_reset_mid();
        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

endmodule
